seq_detect_prog: RTL and testbench

- Programmable serial bit-pattern detector; successor to the fixed 4-bit "1101" Mealy detector FSM.
- Generalised to PAT_W-bit patterns, loadable at run time, with selectable overlapping or non-overlapping detection.
- Adds a registered match pulse and a saturating match counter.
- Sits on a serial input stream qualified by a valid strobe; the match pulse feeds interrupt or event logic.

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_detect_prog_sat_counter.sv | 26 ++
 rtl/seq_detect_prog.sv | 87 ++++++++
 tb/tb_seq_detect_prog.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the programmable sequence detector.
package seq_detect_pkg;

  localparam int unsigned DEF_PAT_W = 4;
  localparam int unsigned DEF_CNT_W = 8;

  // Fill-level of the history register: empty, partial, full.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } state_t;

endpackage

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: clk, rst_n, inc (count one), clr (sync clear), q (count), sat (q is all-ones, combinational).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         sat
);

  assign sat = &q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !sat) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with overlap control and match counter.
// Ports: clk, rst_n (async, active low), in_valid/s (qualified serial bit),
//        pat_load/pat_in (new pattern, MSB first in time), overlap_en, cnt_clr,
//        match (registered one-cycle pulse), match_cnt (saturating), cnt_sat.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int unsigned       PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0]  PAT_RST = 4'b1101,
  parameter int unsigned       CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             s,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
  logic               hit;

  // State, pattern, history and match pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= PAT_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      match   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match   <= hit;
    end
  end

  // Next-state: load beats sampling; a non-overlapping hit restarts the fill.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    hit        = 1'b0;
    hist_shift = {hist_q[PAT_W-2:0], s};
    fill_inc   = (state_q == ARMED) ? fill_q : fill_q + FILL_W'(1);

    if (pat_load) begin
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = IDLE;
    end else if (in_valid) begin
      hist_d  = hist_shift;
      fill_d  = fill_inc;
      state_d = (fill_inc == FILL_FULL) ? ARMED : FILLING;
      hit     = (fill_inc == FILL_FULL) && (hist_shift == pat_q);
      if (hit && !overlap_en) begin
        fill_d  = '0;
        state_d = IDLE;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit),
    .clr   (cnt_clr),
    .q     (match_cnt),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench: two detector instances (4-bit/8-bit counter and 2-bit/2-bit counter)
// share one stimulus stream and are compared each cycle against a queue-based model.
module tb_seq_detect_prog;

  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, s, pat_load, overlap_en, cnt_clr;
  logic [3:0] pat_in;

  logic       match0, cnt_sat0, match1, cnt_sat1;
  logic [7:0] match_cnt0;
  logic [1:0] match_cnt1;

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance
  bitq_t      hq0, hq1;
  logic [3:0] mpat[2];
  int         mcnt[2];
  bit         mhit[2];
  int         wid[2]  = '{4, 2};
  int         cmax[2] = '{255, 3};
  logic       ov_cur;

  always #5 clk = ~clk;

  seq_detect_prog #(.PAT_W(4), .PAT_RST(4'b1101), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s(s), .pat_load(pat_load),
    .pat_in(pat_in), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .match(match0), .match_cnt(match_cnt0), .cnt_sat(cnt_sat0)
  );

  seq_detect_prog #(.PAT_W(2), .PAT_RST(2'b11), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s(s), .pat_load(pat_load),
    .pat_in(pat_in[1:0]), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .match(match1), .match_cnt(match_cnt1), .cnt_sat(cnt_sat1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // True when the last w received bits equal the w-bit pattern (MSB first).
  function automatic bit tail_eq(input bitq_t q, input int w, input logic [3:0] p);
    if (q.size() != w) return 1'b0;
    for (int i = 0; i < w; i++)
      if (q[i] != p[w-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_one(input int k, input bitq_t qi, output bitq_t qo);
    bit h = 1'b0;
    qo = qi;
    if (pat_load) begin
      mpat[k] = (k == 0) ? pat_in : {2'b00, pat_in[1:0]};
      qo = {};
    end else if (in_valid) begin
      qo.push_back(s);
      if (qo.size() > wid[k]) void'(qo.pop_front());
      h = tail_eq(qo, wid[k], mpat[k]);
      if (h && !overlap_en) qo = {};
    end
    if (cnt_clr) mcnt[k] = 0;
    else if (h && mcnt[k] < cmax[k]) mcnt[k]++;
    mhit[k] = h;
  endtask

  task automatic model_reset();
    hq0 = {}; hq1 = {};
    mpat[0] = 4'b1101; mpat[1] = 4'b0011;
    mcnt[0] = 0; mcnt[1] = 0;
    mhit[0] = 0; mhit[1] = 0;
  endtask

  task automatic check_all();
    chk("match0",   32'(match0),     32'(mhit[0]));
    chk("cnt0",     32'(match_cnt0), 32'(mcnt[0]));
    chk("sat0",     32'(cnt_sat0),   32'(mcnt[0] == cmax[0]));
    chk("match1",   32'(match1),     32'(mhit[1]));
    chk("cnt1",     32'(match_cnt1), 32'(mcnt[1]));
    chk("sat1",     32'(cnt_sat1),   32'(mcnt[1] == cmax[1]));
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic step(input logic v, input logic b, input logic ld, input logic [3:0] pi,
                      input logic clr);
    bitq_t t;
    in_valid = v; s = b; pat_load = ld; pat_in = pi; cnt_clr = clr; overlap_en = ov_cur;
    @(posedge clk);
    model_one(0, hq0, t); hq0 = t;
    model_one(1, hq1, t); hq1 = t;
    #1;
    check_all();
  endtask

  task automatic send(input logic b);
    step(1'b1, b, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic gap();
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_match0", 32'(match0), 32'd0);
    chk("rst_cnt0",   32'(match_cnt0), 32'd0);
    chk("rst_match1", 32'(match1), 32'd0);
    chk("rst_cnt1",   32'(match_cnt1), 32'd0);
    chk("rst_sat1",   32'(cnt_sat1), 32'd0);
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; s = 0; pat_load = 0; pat_in = 0; overlap_en = 1; cnt_clr = 0;
    ov_cur = 1'b1;
    #12;
    do_reset();

    // 1101101 overlapping: hits after bits 4 and 7
    send_bits(8'b0110_1101, 7);
    chk("ov_cnt", 32'(match_cnt0), 32'd2);
    do_reset();

    // Same stream non-overlapping: one hit
    ov_cur = 1'b0;
    send_bits(8'b0110_1101, 7);
    chk("nov_cnt", 32'(match_cnt0), 32'd1);

    // Pattern 1111, six 1s, both modes
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    ov_cur = 1'b1;
    send_bits(8'b0011_1111, 6);
    chk("p1111_ov", 32'(match_cnt0), 32'd3);
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    ov_cur = 1'b0;
    send_bits(8'b0011_1111, 6);
    chk("p1111_nov", 32'(match_cnt0), 32'd1);

    // Gaps between bits of 1101
    do_reset();
    send(1); gap(); gap(); gap(); send(1); gap(); gap(); gap(); send(0);
    gap(); gap(); gap(); send(1);
    chk("gap_cnt", 32'(match_cnt0), 32'd1);

    // Reset after 110 loses history; pattern back to 1101
    send_bits(8'b0000_0110, 3);
    do_reset();
    send(1);
    chk("rst_nomatch", 32'(match0), 32'd0);
    send_bits(8'b0000_1101, 4);
    chk("rst_pat", 32'(match0), 32'd1);

    // Load coincident with a sample discards that bit
    step(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
    send_bits(8'b0000_1011, 4);
    chk("ld_match", 32'(match0), 32'd1);

    // 2-bit instance: saturate then clear on a hit
    do_reset();
    ov_cur = 1'b1;
    send_bits(8'b0001_1111, 5);
    chk("sat_cnt", 32'(match_cnt1), 32'd3);
    chk("sat_flag", 32'(cnt_sat1), 32'd1);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    chk("clr_hit_m", 32'(match1), 32'd1);
    chk("clr_hit_c", 32'(match_cnt1), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      if ($urandom_range(0, 19) == 0) ov_cur = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
